// File: rtl/edge_io_pkg.sv
// Shared constants, FSM state encoding and byte-array types for the edge_detect
// memory path (edge_mem_responder and its padding helper).
package edge_io_pkg;

    localparam int MAX_RD = 20;
    localparam int MAX_WR = 10;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        WAIT,
        PAD
    } edgeState_t;

    typedef logic [MAX_RD-1:0][7:0] rdWindow_t;
    typedef logic [MAX_WR-1:0][7:0] wrBurst_t;

endpackage

// File: rtl/edge_pad_fill.sv
// Combinational window builder: replicates the edge pixel so a short read still
// fills a full MAX_RD-byte window, aligned to the image edge the anchor implies.
module edge_pad_fill #(
    parameter int MAX_RD = edge_io_pkg::MAX_RD
) (
    input  logic [MAX_RD-1:0][7:0] i_raw,
    input  logic [4:0]             i_len,
    input  logic [15:0]            i_anchorX,
    output logic [MAX_RD-1:0][7:0] o_window
);
    import edge_io_pkg::*;

    int                     w_len;
    int                     w_off;
    logic [MAX_RD-1:0][7:0] w_shiftR;
    logic [MAX_RD-1:0][7:0] w_shiftL;

    // Anchor 0 means the window hangs off the left image edge, so the data sits at
    // the right end and raw[0] fills in front; otherwise raw[L-1] fills behind.
    always_comb begin
        w_len    = int'(i_len);
        w_off    = 0;
        w_shiftR = i_raw;
        w_shiftL = i_raw;
        o_window = i_raw;
        if (w_len > 0 && w_len < MAX_RD) begin
            w_off    = MAX_RD - w_len;
            w_shiftR = i_raw << (8 * w_off);
            w_shiftL = i_raw >> (8 * (w_len - 1));
            for (int j = 0; j < MAX_RD; j++) begin
                if (i_anchorX == 16'd0) begin
                    o_window[j] = (j < w_off) ? i_raw[0] : w_shiftR[j];
                end else begin
                    o_window[j] = (j < w_len) ? i_raw[j] : w_shiftL[0];
                end
            end
        end
    end

endmodule

// File: rtl/edge_mem_responder.sv
// Services one edge_detect request: a byte-serial SRAM write burst, then a read
// burst whose bytes are padded into a fixed-size window.
module edge_mem_responder #(
    parameter int MAX_RD = edge_io_pkg::MAX_RD,
    parameter int MAX_WR = edge_io_pkg::MAX_WR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   io_start,
    input  logic [31:0]            read_start_address,
    input  logic [4:0]             read_length,
    input  logic [15:0]            anchor_x,
    input  logic [31:0]            write_start_address,
    input  logic [4:0]             write_length,
    input  logic [MAX_WR-1:0][7:0] write_data,
    output logic [MAX_RD-1:0][7:0] read_data,
    output logic                   io_final,
    output logic [31:0]            mem_addr,
    output logic                   mem_ren,
    output logic                   mem_wen,
    output logic [7:0]             mem_wdata,
    input  logic [7:0]             mem_rdata,
    input  logic                   mem_stall
);
    import edge_io_pkg::*;

    localparam logic [4:0] RD_LIMIT = 5'(MAX_RD);
    localparam logic [4:0] WR_LIMIT = 5'(MAX_WR);

    edgeState_t             r_state;
    edgeState_t             w_nextState;
    logic [31:0]            r_rdAddr;
    logic [31:0]            r_wrAddr;
    logic [4:0]             r_rdLen;
    logic [4:0]             r_wrLen;
    logic [15:0]            r_anchorX;
    logic [MAX_WR-1:0][7:0] r_wrData;
    logic [4:0]             r_idx;
    logic                   r_capValid;
    logic [4:0]             r_capIdx;
    logic [MAX_RD-1:0][7:0] r_raw;
    logic [4:0]             w_rdLen;
    logic [4:0]             w_wrLen;
    logic                   w_lastBeat;
    logic [MAX_RD-1:0][7:0] w_window;

    // Oversized lengths saturate rather than wrap.
    assign w_rdLen = (read_length > RD_LIMIT) ? RD_LIMIT : read_length;
    assign w_wrLen = (write_length > WR_LIMIT) ? WR_LIMIT : write_length;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Strobes are decoded from the state so a stall simply holds the current beat.
    always_comb begin
        w_nextState = r_state;
        w_lastBeat  = 1'b0;
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (r_state)
            IDLE: begin
                if (io_start) begin
                    if (w_wrLen != 5'd0) begin
                        w_nextState = WRITE;
                    end else if (w_rdLen != 5'd0) begin
                        w_nextState = READ;
                    end else begin
                        w_nextState = WAIT;
                    end
                end
            end
            WRITE: begin
                mem_wen  = 1'b1;
                mem_addr = r_wrAddr + 32'(r_idx);
                for (int i = 0; i < MAX_WR; i++) begin
                    if (r_idx == 5'(i)) begin
                        mem_wdata = r_wrData[i];
                    end
                end
                w_lastBeat = (r_idx == r_wrLen - 5'd1);
                if (!mem_stall && w_lastBeat) begin
                    w_nextState = (r_rdLen != 5'd0) ? READ : WAIT;
                end
            end
            READ: begin
                mem_ren    = 1'b1;
                mem_addr   = r_rdAddr + 32'(r_idx);
                w_lastBeat = (r_idx == r_rdLen - 5'd1);
                if (!mem_stall && w_lastBeat) begin
                    w_nextState = WAIT;
                end
            end
            WAIT:    w_nextState = PAD;
            PAD:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    edge_pad_fill #(
        .MAX_RD(MAX_RD)
    ) u_padFill (
        .i_raw     (r_raw),
        .i_len     (r_rdLen),
        .i_anchorX (r_anchorX),
        .o_window  (w_window)
    );

    // Read data arrives the cycle after an accepted strobe, so the beat index is
    // carried one cycle alongside a valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdAddr   <= '0;
            r_wrAddr   <= '0;
            r_rdLen    <= '0;
            r_wrLen    <= '0;
            r_anchorX  <= '0;
            r_wrData   <= '0;
            r_idx      <= '0;
            r_capValid <= 1'b0;
            r_capIdx   <= '0;
            r_raw      <= '0;
            read_data  <= '0;
            io_final   <= 1'b1;
        end else begin
            r_capValid <= (r_state == READ) && !mem_stall;
            r_capIdx   <= r_idx;
            for (int i = 0; i < MAX_RD; i++) begin
                if (r_capValid && r_capIdx == 5'(i)) begin
                    r_raw[i] <= mem_rdata;
                end
            end
            case (r_state)
                IDLE: begin
                    if (io_start) begin
                        r_rdAddr  <= read_start_address;
                        r_wrAddr  <= write_start_address;
                        r_rdLen   <= w_rdLen;
                        r_wrLen   <= w_wrLen;
                        r_anchorX <= anchor_x;
                        r_wrData  <= write_data;
                        r_idx     <= '0;
                        io_final  <= 1'b0;
                    end
                end
                WRITE, READ: begin
                    if (!mem_stall) begin
                        r_idx <= w_lastBeat ? 5'd0 : r_idx + 5'd1;
                    end
                end
                PAD: begin
                    if (r_rdLen != 5'd0) begin
                        read_data <= w_window;
                    end
                    io_final <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_mem_responder.sv
// Directed bench for edge_mem_responder with a 1 KiB byte SRAM model that honours
// mem_stall and returns read data one cycle after an accepted strobe.
module tb_edge_mem_responder;
    import edge_io_pkg::*;

    localparam int RD = 20;
    localparam int WR = 10;

    logic                clk = 1'b0;
    logic                rst;
    logic                io_start;
    logic [31:0]         read_start_address;
    logic [4:0]          read_length;
    logic [15:0]         anchor_x;
    logic [31:0]         write_start_address;
    logic [4:0]          write_length;
    logic [WR-1:0][7:0]  write_data;
    logic [RD-1:0][7:0]  read_data;
    logic                io_final;
    logic [31:0]         mem_addr;
    logic                mem_ren;
    logic                mem_wen;
    logic [7:0]          mem_wdata;
    logic [7:0]          mem_rdata;
    logic                mem_stall;

    int nChecks = 0;
    int nFails  = 0;

    logic [7:0]  sram [0:1023];
    logic        preWe;
    logic [9:0]  preAddr;
    logic [7:0]  preData;
    int          nReads = 0;
    int          nWrites = 0;
    int          nBoth = 0;
    logic [31:0] lastReadAddr = '0;

    logic        holdPending = 1'b0;
    logic [41:0] holdSnap = '0;

    logic [RD-1:0][7:0] expWin;
    int                 edges;
    int                 readsBefore;
    int                 writesBefore;

    edge_mem_responder #(
        .MAX_RD(RD),
        .MAX_WR(WR)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .io_start            (io_start),
        .read_start_address  (read_start_address),
        .read_length         (read_length),
        .anchor_x            (anchor_x),
        .write_start_address (write_start_address),
        .write_length        (write_length),
        .write_data          (write_data),
        .read_data           (read_data),
        .io_final            (io_final),
        .mem_addr            (mem_addr),
        .mem_ren             (mem_ren),
        .mem_wen             (mem_wen),
        .mem_wdata           (mem_wdata),
        .mem_rdata           (mem_rdata),
        .mem_stall           (mem_stall)
    );

    always #5 clk = ~clk;

    // SRAM model: preload port plus the DUT port, both gated on the clock edge.
    always @(posedge clk) begin
        if (preWe) sram[preAddr] <= preData;
        if (mem_wen && !mem_stall) begin
            sram[mem_addr[9:0]] <= mem_wdata;
            nWrites <= nWrites + 1;
        end
        if (mem_ren && !mem_stall) begin
            mem_rdata    <= sram[mem_addr[9:0]];
            nReads       <= nReads + 1;
            lastReadAddr <= mem_addr;
        end
    end

    task automatic checkOutput(input string tag, input logic [159:0] observed, input logic [159:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // A strobe seen under stall must reappear unchanged on the following cycle.
    always @(negedge clk) begin
        if (mem_ren && mem_wen) nBoth++;
        if (holdPending && !rst) begin
            checkOutput("stall_hold", 160'({mem_ren, mem_wen, mem_wdata, mem_addr}), 160'(holdSnap));
        end
        holdPending = mem_stall && (mem_ren || mem_wen);
        holdSnap    = {mem_ren, mem_wen, mem_wdata, mem_addr};
    end

    task automatic pokeMem(input int addr, input logic [7:0] data);
        @(negedge clk);
        preWe   = 1'b1;
        preAddr = 10'(addr);
        preData = data;
    endtask

    task automatic endPoke();
        @(negedge clk);
        preWe = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] wAddr, input logic [4:0] wLen, input logic [31:0] rAddr,
                                 input logic [4:0] rLen, input logic [15:0] anchor);
        @(negedge clk);
        write_start_address = wAddr;
        write_length        = wLen;
        read_start_address  = rAddr;
        read_length         = rLen;
        anchor_x            = anchor;
        io_start            = 1'b1;
    endtask

    // Edge 0 is the edge that samples io_start; returns the edge index where io_final is seen high.
    task automatic runToFinal(input int budget, input logic [63:0] stallMask, input int pokeEdge, output int count);
        @(posedge clk);
        #1;
        io_start  = 1'b0;
        mem_stall = stallMask[0];
        count     = 0;
        while (count < budget) begin
            @(posedge clk);
            count++;
            #1;
            if (count == pokeEdge) begin
                io_start           = 1'b1;
                read_start_address = 32'hDEAD_0000;
                read_length        = 5'd1;
            end else begin
                io_start = 1'b0;
            end
            mem_stall = (count < 64) ? stallMask[count] : 1'b0;
            if (io_final) break;
        end
        io_start  = 1'b0;
        mem_stall = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; io_start = 1'b0; mem_stall = 1'b0; preWe = 1'b0; preAddr = '0; preData = '0;
        read_start_address = '0; read_length = '0; anchor_x = '0;
        write_start_address = '0; write_length = '0; write_data = '0;

        $display("[TB] preloading 30x30 image");
        for (int a = 0; a < 900; a++) begin
            pokeMem(a, ((a % 30) >= 5 && (a % 30) <= 24 && (a / 30) >= 10 && (a / 30) <= 19) ? 8'd200 : 8'd30);
        end
        endPoke();
        rst = 1'b0;
        checkOutput("rst_io_final", 160'(io_final), 160'(1'b1));
        checkOutput("rst_read_data", read_data, 160'd0);
        checkOutput("rst_strobes", 160'({mem_ren, mem_wen}), 160'd0);
        checkOutput("rst_mem_addr", 160'(mem_addr), 160'd0);
        checkOutput("rst_mem_wdata", 160'(mem_wdata), 160'd0);

        $display("[TB] image row read, full window");
        readsBefore = nReads;
        applyStimulus(32'd0, 5'd0, 32'd300, 5'd20, 16'd7);
        runToFinal(60, 64'd0, -1, edges);
        checkOutput("img_edges", 160'(edges), 160'(22));
        for (int k = 0; k < RD; k++) expWin[k] = (k < 5) ? 8'd30 : 8'd200;
        checkOutput("img_window", read_data, expWin);
        checkOutput("img_reads", 160'(nReads - readsBefore), 160'(20));

        $display("[TB] left edge, right-aligned padding");
        for (int a = 0; a < 15; a++) pokeMem(a, 8'(a + 1));
        endPoke();
        applyStimulus(32'd0, 5'd0, 32'd0, 5'd15, 16'd0);
        runToFinal(60, 64'd0, -1, edges);
        checkOutput("left_edges", 160'(edges), 160'(17));
        for (int k = 0; k < RD; k++) expWin[k] = (k < 5) ? 8'd1 : 8'(k - 4);
        checkOutput("left_window", read_data, expWin);

        $display("[TB] right edge, left-aligned padding");
        for (int a = 0; a < 7; a++) pokeMem(500 + a, 8'(9 + a));
        endPoke();
        applyStimulus(32'd0, 5'd0, 32'd500, 5'd7, 16'd23);
        runToFinal(60, 64'd0, -1, edges);
        checkOutput("right_edges", 160'(edges), 160'(9));
        for (int k = 0; k < RD; k++) expWin[k] = (k < 7) ? 8'(9 + k) : 8'd15;
        checkOutput("right_window", read_data, expWin);

        $display("[TB] write burst with three stall cycles");
        for (int i = 0; i < WR; i++) write_data[i] = 8'hA0 + 8'(i);
        writesBefore = nWrites;
        applyStimulus(32'd100, 5'd10, 32'd0, 5'd0, 16'd0);
        runToFinal(60, 64'h4C, -1, edges);
        checkOutput("wr_edges", 160'(edges), 160'(15));
        checkOutput("wr_count", 160'(nWrites - writesBefore), 160'(10));
        checkOutput("wr_window_kept", read_data, expWin);
        for (int i = 0; i < WR; i++) checkOutput("wr_sram", 160'(sram[100 + i]), 160'(8'hA0 + 8'(i)));

        $display("[TB] oversized lengths and ignored busy start");
        for (int a = 0; a < 10; a++) pokeMem(610 + a, 8'h50 + 8'(a));
        endPoke();
        for (int i = 0; i < WR; i++) write_data[i] = 8'hB0 + 8'(i);
        readsBefore  = nReads;
        writesBefore = nWrites;
        applyStimulus(32'd600, 5'd12, 32'd600, 5'd25, 16'd3);
        runToFinal(80, 64'd0, 5, edges);
        checkOutput("ovf_edges", 160'(edges), 160'(32));
        checkOutput("ovf_writes", 160'(nWrites - writesBefore), 160'(10));
        checkOutput("ovf_reads", 160'(nReads - readsBefore), 160'(20));
        checkOutput("ovf_last_addr", 160'(lastReadAddr), 160'(32'd619));
        for (int k = 0; k < RD; k++) expWin[k] = (k < 10) ? 8'hB0 + 8'(k) : 8'h50 + 8'(k - 10);
        checkOutput("ovf_window", read_data, expWin);

        $display("[TB] address wrap past 0xFFFFFFFF");
        pokeMem(1022, 8'h77);
        pokeMem(1023, 8'h88);
        endPoke();
        applyStimulus(32'd0, 5'd0, 32'hFFFF_FFFE, 5'd3, 16'd5);
        runToFinal(60, 64'd0, -1, edges);
        checkOutput("wrap_edges", 160'(edges), 160'(5));
        checkOutput("wrap_last_addr", 160'(lastReadAddr), 160'd0);
        for (int k = 0; k < RD; k++) expWin[k] = (k == 0) ? 8'h77 : (k == 1) ? 8'h88 : 8'h01;
        checkOutput("wrap_window", read_data, expWin);

        $display("[TB] reset during the fourth read cycle");
        applyStimulus(32'd0, 5'd0, 32'd300, 5'd10, 16'd0);
        @(posedge clk);
        #1 io_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_strobes", 160'({mem_ren, mem_wen}), 160'd0);
        checkOutput("abort_io_final", 160'(io_final), 160'(1'b1));
        checkOutput("abort_read_data", read_data, 160'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_stays_idle", 160'({io_final, mem_ren, mem_wen}), 160'(3'b100));

        $display("[TB] fresh request after abort");
        write_data    = '0;
        write_data[0] = 8'hC1;
        write_data[1] = 8'hC2;
        applyStimulus(32'd700, 5'd2, 32'd700, 5'd2, 16'd1);
        runToFinal(60, 64'd0, -1, edges);
        checkOutput("fresh_edges", 160'(edges), 160'(6));
        checkOutput("fresh_sram", 160'({sram[701], sram[700]}), 160'(16'hC2C1));
        for (int k = 0; k < RD; k++) expWin[k] = (k == 0) ? 8'hC1 : 8'hC2;
        checkOutput("fresh_window", read_data, expWin);

        $display("[TB] empty request");
        applyStimulus(32'd0, 5'd0, 32'd0, 5'd0, 16'd0);
        runToFinal(60, 64'd0, -1, edges);
        checkOutput("empty_edges", 160'(edges), 160'(2));
        checkOutput("empty_window_kept", read_data, expWin);

        checkOutput("never_both_strobes", 160'(nBoth), 160'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
